spi_cs_ctrl: RTL and testbench

Parametrised multi-slave SPI chip-select controller. It is the successor to the single-line slave-select block and sits between the SPI master FSM and the Pmod/sensor slaves. It drives one of NUM_SLAVES active-low CS lines and enforces programmable CS-to-SCLK lead, SCLK-to-CS lag and minimum deselect gap times. It tells the master when SCLK may start (cs_ready) and when a new frame may be requested (busy).

---
 rtl/spi_cs_pkg.sv | 36 +++
 rtl/spi_cs_delay_cnt.sv | 33 +++
 rtl/spi_cs_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_spi_cs_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/spi_cs_pkg.sv
// rtl/spi_cs_pkg.sv - shared types and helpers for the SPI chip-select controller
//
// Contents:
//   cs_state_t     FSM state encoding (IDLE, LEAD, ACTIVE, LAG, GAP)
//   CS_IDLE_LEVEL  level of a deselected chip-select line
//   clog2()        ceiling log2, used to size the delay counter
//   max_of()       larger of two integers, used for counter sizing
package spi_cs_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEAD   = 3'd1,
        ACTIVE = 3'd2,
        LAG    = 3'd3,
        GAP    = 3'd4
    } cs_state_t;

    localparam logic CS_IDLE_LEVEL = 1'b1;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/spi_cs_delay_cnt.sv
// rtl/spi_cs_delay_cnt.sv - loadable down-counter for state timing and watchdog
//
// Ports:
//   clk       system clock
//   rst_n     asynchronous active-low reset
//   load      load strobe; load_val is taken on this edge
//   load_val  initial count (number of cycles the owner wants to wait)
//   count     current count, decrements to 0 and holds there
//   expire    high while count == 1, i.e. during the last cycle of the wait
module spi_cs_delay_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] count,
    output logic         expire
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign expire = (count == W'(1));

endmodule

// File: rtl/spi_cs_ctrl.sv
// rtl/spi_cs_ctrl.sv - multi-slave SPI chip-select controller with lead/lag/gap timing
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   transmit   frame request, sampled only in IDLE
//   slave_sel  target slave index, captured with transmit
//   done       end-of-frame pulse, honoured in LEAD (abort) and ACTIVE
//   cs         active-low chip selects, at most one low
//   cs_ready   high while SCLK may toggle (ACTIVE)
//   busy       high from request accept until the gap ends
//   sel_err    one-cycle pulse on a request with slave_sel >= NUM_SLAVES
//   timeout    one-cycle pulse on watchdog expiry
//
// Build option: define SPI_CS_TIMEOUT_EN to enable the ACTIVE-state watchdog;
// otherwise timeout is tied low and ACTIVE waits for done indefinitely.
module spi_cs_ctrl
    import spi_cs_pkg::*;
#(
    parameter int NUM_SLAVES  = 4,
    parameter int SEL_W       = 2,
    parameter int LEAD_CYC    = 2,
    parameter int LAG_CYC     = 2,
    parameter int GAP_CYC     = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  transmit,
    input  logic [SEL_W-1:0]      slave_sel,
    input  logic                  done,
    output logic [NUM_SLAVES-1:0] cs,
    output logic                  cs_ready,
    output logic                  busy,
    output logic                  sel_err,
    output logic                  timeout
);

    localparam int CNT_MAX = max_of(max_of(LEAD_CYC, LAG_CYC), max_of(GAP_CYC, TIMEOUT_CYC));
    localparam int CNT_W   = (clog2(CNT_MAX + 1) < 1) ? 1 : clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] LEAD_V = CNT_W'(LEAD_CYC);
    localparam logic [CNT_W-1:0] LAG_V  = CNT_W'(LAG_CYC);
    localparam logic [CNT_W-1:0] GAP_V  = CNT_W'(GAP_CYC);

    // Zero-length states are skipped, so the state following a frame end
    // (done, abort or watchdog) and the one following LAG are fixed at elaboration.
    localparam cs_state_t        POST_ACTIVE   = (LAG_CYC > 0) ? LAG : ((GAP_CYC > 0) ? GAP : IDLE);
    localparam logic [CNT_W-1:0] POST_ACTIVE_V = (LAG_CYC > 0) ? LAG_V : GAP_V;
    localparam cs_state_t        POST_LAG      = (GAP_CYC > 0) ? GAP : IDLE;

    cs_state_t              state;
    cs_state_t              state_nxt;
    logic [SEL_W-1:0]       sel_q;
    logic [SEL_W-1:0]       sel_nxt;
    logic                   load;
    logic [CNT_W-1:0]       load_val;
    logic [CNT_W-1:0]       cnt;
    logic                   cnt_expire;
    logic                   sel_valid;
    logic                   sel_err_nxt;
    logic [NUM_SLAVES-1:0]  cs_nxt;

`ifdef SPI_CS_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT_CYC);
    logic timeout_nxt;
    logic timeout_q;
`endif

    assign sel_valid = (int'(slave_sel) < NUM_SLAVES);

    spi_cs_delay_cnt #(
        .W(CNT_W)
    ) u_delay_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .load_val (load_val),
        .count    (cnt),
        .expire   (cnt_expire)
    );

    always_comb begin
        state_nxt   = state;
        sel_nxt     = sel_q;
        load        = 1'b0;
        load_val    = '0;
        sel_err_nxt = 1'b0;
`ifdef SPI_CS_TIMEOUT_EN
        timeout_nxt = 1'b0;
`endif
        case (state)
            IDLE: begin
                // transmit has priority; done is meaningless here
                if (transmit) begin
                    if (sel_valid) begin
                        sel_nxt = slave_sel;
                        if (LEAD_CYC > 0) begin
                            state_nxt = LEAD;
                            load      = 1'b1;
                            load_val  = LEAD_V;
                        end else begin
                            state_nxt = ACTIVE;
`ifdef SPI_CS_TIMEOUT_EN
                            load      = 1'b1;
                            load_val  = TIMEOUT_V;
`endif
                        end
                    end else begin
                        sel_err_nxt = 1'b1;
                    end
                end
            end
            LEAD: begin
                if (done) begin
                    state_nxt = POST_ACTIVE;
                    load      = 1'b1;
                    load_val  = POST_ACTIVE_V;
                end else if (cnt_expire) begin
                    state_nxt = ACTIVE;
`ifdef SPI_CS_TIMEOUT_EN
                    load      = 1'b1;
                    load_val  = TIMEOUT_V;
`endif
                end
            end
            ACTIVE: begin
                if (done) begin
                    state_nxt = POST_ACTIVE;
                    load      = 1'b1;
                    load_val  = POST_ACTIVE_V;
                end
`ifdef SPI_CS_TIMEOUT_EN
                else if (cnt_expire) begin
                    state_nxt   = POST_ACTIVE;
                    load        = 1'b1;
                    load_val    = POST_ACTIVE_V;
                    timeout_nxt = 1'b1;
                end
`endif
            end
            LAG: begin
                if (cnt_expire) begin
                    state_nxt = POST_LAG;
                    load      = 1'b1;
                    load_val  = GAP_V;
                end
            end
            GAP: begin
                if (cnt_expire) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_comb begin
        cs_nxt = {NUM_SLAVES{CS_IDLE_LEVEL}};
        if (state_nxt == LEAD || state_nxt == ACTIVE || state_nxt == LAG) begin
            for (int i = 0; i < NUM_SLAVES; i++) begin
                if (int'(sel_nxt) == i) begin
                    cs_nxt[i] = ~CS_IDLE_LEVEL;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            sel_q    <= '0;
            cs       <= {NUM_SLAVES{CS_IDLE_LEVEL}};
            cs_ready <= 1'b0;
            busy     <= 1'b0;
            sel_err  <= 1'b0;
        end else begin
            state    <= state_nxt;
            sel_q    <= sel_nxt;
            cs       <= cs_nxt;
            cs_ready <= (state_nxt == ACTIVE);
            busy     <= (state_nxt != IDLE);
            sel_err  <= sel_err_nxt;
        end
    end

`ifdef SPI_CS_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_nxt;
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_spi_cs_ctrl.sv
// tb/tb_spi_cs_ctrl.sv - directed self-checking bench for spi_cs_ctrl
module tb_spi_cs_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    // u_a: 4 slaves, lead 2, lag 3, gap 4, watchdog 16
    logic       a_tx = 1'b0;
    logic       a_done = 1'b0;
    logic [1:0] a_sel = 2'd0;
    logic [3:0] a_cs;
    logic       a_ready, a_busy, a_err, a_to;

    // u_b: 3 slaves, default timing
    logic       b_tx = 1'b0;
    logic       b_done = 1'b0;
    logic [1:0] b_sel = 2'd0;
    logic [2:0] b_cs;
    logic       b_ready, b_busy, b_err, b_to;

    // u_c: 4 slaves, all delays zero
    logic       c_tx = 1'b0;
    logic       c_done = 1'b0;
    logic [1:0] c_sel = 2'd0;
    logic [3:0] c_cs;
    logic       c_ready, c_busy, c_err, c_to;

    int errors = 0;
    int checks = 0;

    spi_cs_ctrl #(
        .NUM_SLAVES(4), .SEL_W(2), .LEAD_CYC(2), .LAG_CYC(3), .GAP_CYC(4), .TIMEOUT_CYC(16)
    ) u_a (
        .clk(clk), .rst_n(rst_n), .transmit(a_tx), .slave_sel(a_sel), .done(a_done),
        .cs(a_cs), .cs_ready(a_ready), .busy(a_busy), .sel_err(a_err), .timeout(a_to)
    );

    spi_cs_ctrl #(
        .NUM_SLAVES(3), .SEL_W(2), .LEAD_CYC(2), .LAG_CYC(2), .GAP_CYC(4), .TIMEOUT_CYC(1024)
    ) u_b (
        .clk(clk), .rst_n(rst_n), .transmit(b_tx), .slave_sel(b_sel), .done(b_done),
        .cs(b_cs), .cs_ready(b_ready), .busy(b_busy), .sel_err(b_err), .timeout(b_to)
    );

    spi_cs_ctrl #(
        .NUM_SLAVES(4), .SEL_W(2), .LEAD_CYC(0), .LAG_CYC(0), .GAP_CYC(0), .TIMEOUT_CYC(1024)
    ) u_c (
        .clk(clk), .rst_n(rst_n), .transmit(c_tx), .slave_sel(c_sel), .done(c_done),
        .cs(c_cs), .cs_ready(c_ready), .busy(c_busy), .sel_err(c_err), .timeout(c_to)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_a_cs",    32'(a_cs),    'hF);
        check("rst_a_ready", 32'(a_ready), 0);
        check("rst_a_busy",  32'(a_busy),  0);
        check("rst_a_to",    32'(a_to),    0);
        check("rst_b_cs",    32'(b_cs),    'h7);
        check("rst_b_err",   32'(b_err),   0);
        check("rst_c_cs",    32'(c_cs),    'hF);
        rst_n = 1'b1;

        // Edge 0: requests on u_a (sel 2) and u_b (invalid sel 3)
        tick();
        a_tx = 1'b1; a_sel = 2'd2;
        b_tx = 1'b1; b_sel = 2'd3;
        tick();                                   // edge 1
        check("e1_a_cs",    32'(a_cs),    'hB);
        check("e1_a_busy",  32'(a_busy),  1);
        check("e1_a_ready", 32'(a_ready), 0);
        check("e1_b_err",   32'(b_err),   1);
        check("e1_b_cs",    32'(b_cs),    'h7);
        check("e1_b_busy",  32'(b_busy),  0);
        a_tx = 1'b0; a_sel = 2'd0;               // mid-frame sel change must be ignored
        b_tx = 1'b0;
        tick();                                   // edge 2
        check("e2_a_ready", 32'(a_ready), 0);
        check("e2_b_err",   32'(b_err),   0);
        check("e2_b_cs",    32'(b_cs),    'h7);
        check("e2_a_cs",    32'(a_cs),    'hB);
        tick();                                   // edge 3
        check("e3_a_ready", 32'(a_ready), 1);
        check("e3_a_cs",    32'(a_cs),    'hB);
        step(7);                                  // edge 10
        check("e10_a_ready", 32'(a_ready), 1);
        a_done = 1'b1;
        tick();                                   // edge 11
        a_done = 1'b0;
        check("e11_a_ready", 32'(a_ready), 0);
        check("e11_a_cs",    32'(a_cs),    'hB);
        step(2);                                  // edge 13
        check("e13_a_cs",    32'(a_cs),    'hB);
        tick();                                   // edge 14
        check("e14_a_cs",    32'(a_cs),    'hF);
        check("e14_a_busy",  32'(a_busy),  1);
        a_tx = 1'b1; a_sel = 2'd1;               // request during GAP, held into IDLE
        tick();                                   // edge 15
        check("e15_a_cs",    32'(a_cs),    'hF);
        step(2);                                  // edge 17
        check("e17_a_cs",    32'(a_cs),    'hF);
        check("e17_a_busy",  32'(a_busy),  1);
        tick();                                   // edge 18
        check("e18_a_busy",  32'(a_busy),  0);
        check("e18_a_cs",    32'(a_cs),    'hF);
        a_done = 1'b1;                            // done together with transmit in IDLE
        tick();                                   // edge 19
        check("e19_a_cs",    32'(a_cs),    'hD);
        check("e19_a_busy",  32'(a_busy),  1);
        check("e19_a_ready", 32'(a_ready), 0);
        a_tx = 1'b0; a_done = 1'b0;
        step(2);                                  // edge 21
        check("e21_a_ready", 32'(a_ready), 1);
        check("e21_a_cs",    32'(a_cs),    'hD);

        // Asynchronous reset in ACTIVE
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("arst_a_cs",    32'(a_cs),    'hF);
        check("arst_a_ready", 32'(a_ready), 0);
        check("arst_a_busy",  32'(a_busy),  0);
        #2 rst_n = 1'b1;
        tick();
        check("post_rst_busy", 32'(a_busy), 0);

        // New frame after reset, no done: watchdog behaviour
        a_tx = 1'b1; a_sel = 2'd0;
        tick();                                   // t1
        check("t1_a_cs",   32'(a_cs),   'hE);
        check("t1_a_busy", 32'(a_busy), 1);
        a_tx = 1'b0;
        step(2);                                  // t3
        check("t3_a_ready", 32'(a_ready), 1);
        step(15);                                 // t18
        check("t18_a_ready", 32'(a_ready), 1);
        check("t18_a_to",    32'(a_to),    0);
        tick();                                   // t19
`ifdef SPI_CS_TIMEOUT_EN
        check("t19_a_to",    32'(a_to),    1);
        check("t19_a_ready", 32'(a_ready), 0);
        check("t19_a_cs",    32'(a_cs),    'hE);
        tick();                                   // t20
        check("t20_a_to",    32'(a_to),    0);
        step(2);                                  // t22
        check("t22_a_cs",    32'(a_cs),    'hF);
        check("t22_a_busy",  32'(a_busy),  1);
        step(4);                                  // t26
        check("t26_a_busy",  32'(a_busy),  0);
`else
        check("t19_a_to",    32'(a_to),    0);
        check("t19_a_ready", 32'(a_ready), 1);
        tick();                                   // t20
        check("t20_a_ready", 32'(a_ready), 1);
        a_done = 1'b1;
        tick();                                   // t21
        a_done = 1'b0;
        check("t21_a_ready", 32'(a_ready), 0);
        step(3);                                  // t24
        check("t24_a_cs",    32'(a_cs),    'hF);
        step(4);                                  // t28
        check("t28_a_busy",  32'(a_busy),  0);
`endif

        // Zero-length lead/lag/gap
        c_tx = 1'b1; c_sel = 2'd0;
        tick();
        check("z1_c_cs",    32'(c_cs),    'hE);
        check("z1_c_ready", 32'(c_ready), 1);
        check("z1_c_busy",  32'(c_busy),  1);
        c_tx = 1'b0; c_sel = 2'd2;
        tick();
        check("z2_c_cs",    32'(c_cs),    'hE);
        c_done = 1'b1;
        tick();
        c_done = 1'b0;
        check("z3_c_cs",    32'(c_cs),    'hF);
        check("z3_c_busy",  32'(c_busy),  0);
        check("z3_c_ready", 32'(c_ready), 0);
        tick();
        check("z4_c_cs",    32'(c_cs),    'hF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
